dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port data memory (DMEM) between the core load/store unit (port 0) and a debug/DMA master (port 1).
- Accepts at most one access per cycle and drives DMEM's RDEN/WEN/BYTE_SEL/SIGN/ADDR/DATA_IN.
- Routes the one-cycle-latency read data back to the requester that issued the read.
- Supports round-robin arbitration, or fixed priority with a starvation guard.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/rr_prio_pick.sv | 61 ++++++
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter and its requesters.
package dmem_pkg;

  // Request fields are sized for the widest supported memory and then trimmed by the users.
  localparam int unsigned REQ_ADDR_MAX = 32;
  localparam int unsigned REQ_DATA_MAX = 64;

  localparam logic [1:0] BSEL_BYTE = 2'b00;
  localparam logic [1:0] BSEL_HALF = 2'b01;
  localparam logic [1:0] BSEL_WORD = 2'b10;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef struct packed {
    logic                    we;
    logic [REQ_ADDR_MAX-1:0] addr;
    logic [REQ_DATA_MAX-1:0] wdata;
    logic [1:0]              bsel;
    logic                    sign;
  } dmem_req_t;

endpackage

// File: rtl/rr_prio_pick.sv
// Two-way winner select, either round-robin or fixed priority with a starvation guard.
module rr_prio_pick
  import dmem_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       winner,
  output logic [3:0] consec_cnt
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  logic       last_winner_reg, last_winner_next;
  logic [3:0] consec_cnt_reg, consec_cnt_next;

  always_comb begin
    winner           = PORT_LSU;
    gnt0             = 1'b0;
    gnt1             = 1'b0;
    last_winner_next = last_winner_reg;
    consec_cnt_next  = consec_cnt_reg;

    if (req0 && req1) begin
      if (FIXED_PRIO) winner = (consec_cnt_reg == MAX_C) ? PORT_DBG : PORT_LSU;
      else            winner = ~last_winner_reg;
    end else if (req1) begin
      winner = PORT_DBG;
    end

    if (RST_N) begin
      gnt0 = req0 && (winner == PORT_LSU);
      gnt1 = req1 && (winner == PORT_DBG);
    end

    if (gnt0 || gnt1) last_winner_next = winner;

    // Only contested port-0 wins count toward the guard; any break in port-1 demand resets it.
    if (!FIXED_PRIO || !req1 || gnt1) consec_cnt_next = 4'd0;
    else if (gnt0 && consec_cnt_reg != MAX_C) consec_cnt_next = consec_cnt_reg + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_winner_reg <= PORT_DBG;
      consec_cnt_reg  <= 4'd0;
    end else begin
      last_winner_reg <= last_winner_next;
      consec_cnt_reg  <= consec_cnt_next;
    end
  end

  assign consec_cnt = consec_cnt_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between the load/store unit (port 0) and the debug/DMA master (port 1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_DEPTH-1:0] ADDR0,
  input  logic [ADDR_DEPTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  input  logic [1:0]            BSEL0,
  input  logic [1:0]            BSEL1,
  input  logic                  SIGN0,
  input  logic                  SIGN1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  RVALID0,
  output logic                  RVALID1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  M_RDEN,
  output logic                  M_WEN,
  output logic [1:0]            M_BYTE_SEL,
  output logic                  M_SIGN,
  output logic [ADDR_DEPTH-1:0] M_ADDR,
  output logic [DATA_WIDTH-1:0] M_DATA_IN,
  input  logic [DATA_WIDTH-1:0] M_DATA_OUT
);

  dmem_req_t req0, req1, sel;
  logic      winner;
  logic      any_gnt;
  logic [3:0] consec_cnt;
  logic      rd_pend_reg, rd_pend_next;
  logic      rd_id_reg, rd_id_next;

  rr_prio_pick #(
    .FIXED_PRIO (FIXED_PRIO),
    .MAX_CONSEC (MAX_CONSEC)
  ) u_pick (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req0       (REQ0),
    .req1       (REQ1),
    .gnt0       (GNT0),
    .gnt1       (GNT1),
    .winner     (winner),
    .consec_cnt (consec_cnt)
  );

  always_comb begin
    req0 = '0;
    req1 = '0;
    req0.we    = WE0;
    req0.addr[ADDR_DEPTH-1:0]  = ADDR0;
    req0.wdata[DATA_WIDTH-1:0] = WDATA0;
    req0.bsel  = BSEL0;
    req0.sign  = SIGN0;
    req1.we    = WE1;
    req1.addr[ADDR_DEPTH-1:0]  = ADDR1;
    req1.wdata[DATA_WIDTH-1:0] = WDATA1;
    req1.bsel  = BSEL1;
    req1.sign  = SIGN1;
  end

  assign any_gnt = GNT0 | GNT1;

  // Idle cycles present an all-zero request so DMEM sees quiet inputs.
  always_comb begin
    sel = '0;
    if (any_gnt) sel = (winner == PORT_DBG) ? req1 : req0;
  end

  assign M_RDEN     = any_gnt & ~sel.we;
  assign M_WEN      = any_gnt &  sel.we;
  assign M_BYTE_SEL = sel.bsel;
  assign M_SIGN     = sel.sign;
  assign M_ADDR     = sel.addr[ADDR_DEPTH-1:0];
  assign M_DATA_IN  = sel.wdata[DATA_WIDTH-1:0];

  always_comb begin
    rd_pend_next = M_RDEN;
    rd_id_next   = M_RDEN ? winner : rd_id_reg;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_pend_reg <= 1'b0;
      rd_id_reg   <= PORT_LSU;
    end else begin
      rd_pend_reg <= rd_pend_next;
      rd_id_reg   <= rd_id_next;
    end
  end

  assign RVALID0 = rd_pend_reg && (rd_id_reg == PORT_LSU);
  assign RVALID1 = rd_pend_reg && (rd_id_reg == PORT_DBG);
  assign RDATA   = M_DATA_OUT;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin vector table with a read scoreboard, plus a fixed-priority sequence.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Round-robin instance signals
  logic        RST_N;
  logic        REQ0, REQ1, WE0, WE1, SIGN0, SIGN1;
  logic [13:0] ADDR0, ADDR1;
  logic [31:0] WDATA0, WDATA1;
  logic [1:0]  BSEL0, BSEL1;
  logic        GNT0, GNT1, RVALID0, RVALID1;
  logic [31:0] RDATA;
  logic        M_RDEN, M_WEN, M_SIGN;
  logic [1:0]  M_BYTE_SEL;
  logic [13:0] M_ADDR;
  logic [31:0] M_DATA_IN, M_DATA_OUT;

  // Fixed-priority instance signals
  logic        f_rst_n, f_req0, f_req1, f_we0, f_we1;
  logic        f_gnt0, f_gnt1, f_rvalid0, f_rvalid1;
  logic [31:0] f_rdata;
  logic        f_rden, f_wen, f_sign;
  logic [1:0]  f_bsel;
  logic [13:0] f_addr;
  logic [31:0] f_din;
  logic [31:0] f_dout;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.ADDR_DEPTH(14), .DATA_WIDTH(32), .FIXED_PRIO(1'b0), .MAX_CONSEC(4)) u_rr (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .BSEL0(BSEL0), .BSEL1(BSEL1), .SIGN0(SIGN0), .SIGN1(SIGN1),
    .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1), .RDATA(RDATA),
    .M_RDEN(M_RDEN), .M_WEN(M_WEN), .M_BYTE_SEL(M_BYTE_SEL), .M_SIGN(M_SIGN),
    .M_ADDR(M_ADDR), .M_DATA_IN(M_DATA_IN), .M_DATA_OUT(M_DATA_OUT)
  );

  dmem_arbiter #(.ADDR_DEPTH(14), .DATA_WIDTH(32), .FIXED_PRIO(1'b1), .MAX_CONSEC(2)) u_fx (
    .CLK(CLK), .RST_N(f_rst_n),
    .REQ0(f_req0), .REQ1(f_req1), .WE0(f_we0), .WE1(f_we1),
    .ADDR0(14'h0100), .ADDR1(14'h0200), .WDATA0(32'h1111_1111), .WDATA1(32'h2222_2222),
    .BSEL0(BSEL_WORD), .BSEL1(BSEL_WORD), .SIGN0(1'b0), .SIGN1(1'b0),
    .GNT0(f_gnt0), .GNT1(f_gnt1), .RVALID0(f_rvalid0), .RVALID1(f_rvalid1), .RDATA(f_rdata),
    .M_RDEN(f_rden), .M_WEN(f_wen), .M_BYTE_SEL(f_bsel), .M_SIGN(f_sign),
    .M_ADDR(f_addr), .M_DATA_IN(f_din), .M_DATA_OUT(f_dout)
  );

  assign f_dout = 32'hFEED_C0DE;

  // Word-wide DMEM stand-in for the round-robin instance: one-cycle registered read.
  logic [31:0] mem [0:16383];
  always @(posedge CLK) begin
    if (M_WEN) mem[M_ADDR] <= M_DATA_IN;
    if (M_RDEN) M_DATA_OUT <= mem[M_ADDR];
  end

  logic [31:0] exp_mem [0:16383];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Read and write strobes must never be asserted together on either instance.
  always @(negedge CLK) begin
    chk("rr_rden_wen_exclusive", {31'd0, M_RDEN & M_WEN}, 32'd0);
    chk("fx_rden_wen_exclusive", {31'd0, f_rden & f_wen}, 32'd0);
  end

  typedef struct {
    string       name;
    logic        rst_n, mid_rst, req0, req1, we0, we1;
    logic [13:0] addr0, addr1;
    logic [31:0] wd0, wd1;
    logic        eg0, eg1;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  function automatic vec_t mkv(string n, logic rst, logic mid, logic r0, logic r1, logic w0, logic w1,
                               logic [13:0] a0, logic [13:0] a1, logic [31:0] d0, logic [31:0] d1,
                               logic g0, logic g1);
    vec_t v;
    v.name = n; v.rst_n = rst; v.mid_rst = mid; v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1;
    v.addr0 = a0; v.addr1 = a1; v.wd0 = d0; v.wd1 = d1; v.eg0 = g0; v.eg1 = g1;
    return v;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    sb_t         e;
    logic        exp_rden, exp_wen;
    logic [13:0] exp_addr;
    logic [31:0] exp_din;
    logic [1:0]  exp_bsel;
    @(posedge CLK);
    #1;
    RST_N = v.rst_n; REQ0 = v.req0; REQ1 = v.req1; WE0 = v.we0; WE1 = v.we1;
    ADDR0 = v.addr0; ADDR1 = v.addr1; WDATA0 = v.wd0; WDATA1 = v.wd1;
    @(negedge CLK);
    // Read responses issued last cycle are due now.
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({v.name, "_rvalid0"}, {31'd0, RVALID0}, {31'd0, e.port == 1'b0});
      chk({v.name, "_rvalid1"}, {31'd0, RVALID1}, {31'd0, e.port == 1'b1});
      chk({v.name, "_rdata"}, RDATA, e.data);
    end else begin
      chk({v.name, "_rvalid0_idle"}, {31'd0, RVALID0}, 32'd0);
      chk({v.name, "_rvalid1_idle"}, {31'd0, RVALID1}, 32'd0);
    end
    chk({v.name, "_gnt0"}, {31'd0, GNT0}, {31'd0, v.eg0});
    chk({v.name, "_gnt1"}, {31'd0, GNT1}, {31'd0, v.eg1});
    exp_rden = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_din = '0; exp_bsel = 2'b00;
    if (v.eg0) begin
      exp_rden = ~v.we0; exp_wen = v.we0; exp_addr = v.addr0; exp_din = v.wd0; exp_bsel = BSEL_WORD;
    end else if (v.eg1) begin
      exp_rden = ~v.we1; exp_wen = v.we1; exp_addr = v.addr1; exp_din = v.wd1; exp_bsel = BSEL_HALF;
    end
    chk({v.name, "_m_rden"}, {31'd0, M_RDEN}, {31'd0, exp_rden});
    chk({v.name, "_m_wen"}, {31'd0, M_WEN}, {31'd0, exp_wen});
    chk({v.name, "_m_addr"}, {18'd0, M_ADDR}, {18'd0, exp_addr});
    chk({v.name, "_m_din"}, M_DATA_IN, exp_din);
    chk({v.name, "_m_bsel"}, {30'd0, M_BYTE_SEL}, {30'd0, exp_bsel});
    if (!v.mid_rst) begin
      if (v.eg0 && !v.we0) sbq.push_back('{port: 1'b0, data: exp_mem[v.addr0]});
      if (v.eg1 && !v.we1) sbq.push_back('{port: 1'b1, data: exp_mem[v.addr1]});
      if (v.eg0 && v.we0) exp_mem[v.addr0] = v.wd0;
      if (v.eg1 && v.we1) exp_mem[v.addr1] = v.wd1;
    end else begin
      #1 RST_N = 1'b0;
    end
    $display("vec %0d %s: req=%b%b gnt=%b%b rvalid=%b%b addr=%h", idx, v.name,
             v.req0, v.req1, GNT0, GNT1, RVALID0, RVALID1, M_ADDR);
  endtask

  initial begin
    logic exp_seq [6];
    RST_N = 1'b0; REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0; ADDR0 = '0; ADDR1 = '0;
    WDATA0 = '0; WDATA1 = '0; BSEL0 = BSEL_WORD; BSEL1 = BSEL_HALF; SIGN0 = 1'b0; SIGN1 = 1'b1;
    f_rst_n = 1'b0; f_req0 = 0; f_req1 = 0; f_we0 = 0; f_we1 = 0;

    for (int i = 0; i < 16384; i++) begin
      mem[i] = 32'd0;
      exp_mem[i] = 32'd0;
    end
    mem[14'h6004] = 32'hDEAD_BEEF; exp_mem[14'h6004] = 32'hDEAD_BEEF;
    mem[14'h6008] = 32'hCAFE_F00D; exp_mem[14'h6008] = 32'hCAFE_F00D;

    //                 name        rst mid r0 r1 w0 w1 addr0     addr1     wdata0 wdata1          g0 g1
    vecs.push_back(mkv("in_reset", 0, 0, 1, 1, 0, 0, 14'h6004, 14'h6008, 0, 0,               0, 0));
    vecs.push_back(mkv("rd0",      1, 0, 1, 0, 0, 0, 14'h6004, 14'h0000, 0, 0,               1, 0));
    vecs.push_back(mkv("idle_a",   1, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 0, 0,               0, 0));
    vecs.push_back(mkv("rd1",      1, 0, 0, 1, 0, 0, 14'h0000, 14'h6008, 0, 0,               0, 1));
    vecs.push_back(mkv("rr_c0",    1, 0, 1, 1, 0, 0, 14'h6004, 14'h6008, 0, 0,               1, 0));
    vecs.push_back(mkv("rr_c1",    1, 0, 1, 1, 0, 0, 14'h6004, 14'h6008, 0, 0,               0, 1));
    vecs.push_back(mkv("rr_c2",    1, 0, 1, 1, 0, 0, 14'h6004, 14'h6008, 0, 0,               1, 0));
    vecs.push_back(mkv("rr_c3",    1, 0, 1, 1, 0, 0, 14'h6004, 14'h6008, 0, 0,               0, 1));
    vecs.push_back(mkv("wr1",      1, 0, 0, 1, 0, 1, 14'h0000, 14'h6010, 0, 32'h1234_5678,   0, 1));
    vecs.push_back(mkv("raw_rd0",  1, 0, 1, 0, 0, 0, 14'h6010, 14'h0000, 0, 0,               1, 0));
    vecs.push_back(mkv("mix_a",    1, 0, 1, 1, 0, 1, 14'h6014, 14'h6014, 0, 32'hA5A5_A5A5,   0, 1));
    vecs.push_back(mkv("mix_b",    1, 0, 1, 0, 0, 1, 14'h6014, 14'h6014, 0, 32'hA5A5_A5A5,   1, 0));
    vecs.push_back(mkv("idle_b",   1, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 0, 0,               0, 0));
    vecs.push_back(mkv("rd_reset", 1, 1, 1, 0, 0, 0, 14'h6004, 14'h0000, 0, 0,               1, 0));
    vecs.push_back(mkv("post_rst", 1, 0, 1, 1, 0, 0, 14'h6004, 14'h6008, 0, 0,               1, 0));
    vecs.push_back(mkv("idle_c",   1, 0, 0, 0, 0, 0, 14'h0000, 14'h0000, 0, 0,               0, 0));

    foreach (vecs[i]) apply_vec(i, vecs[i]);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    // Fixed priority with a guard of two: contested grants run 0,0,1,0,0,1.
    exp_seq[0] = 1'b0; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1;
    exp_seq[3] = 1'b0; exp_seq[4] = 1'b0; exp_seq[5] = 1'b1;
    @(posedge CLK);
    #1 f_rst_n = 1'b1; f_req0 = 1'b1; f_req1 = 1'b1; f_we0 = 1'b1; f_we1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk($sformatf("fx_seq%0d_gnt0", i), {31'd0, f_gnt0}, {31'd0, ~exp_seq[i]});
      chk($sformatf("fx_seq%0d_gnt1", i), {31'd0, f_gnt1}, {31'd0, exp_seq[i]});
      chk($sformatf("fx_seq%0d_wen", i), {31'd0, f_wen}, 32'd1);
      chk($sformatf("fx_seq%0d_rvalid", i), {30'd0, f_rvalid0, f_rvalid1}, 32'd0);
      $display("fx %0d: gnt=%b%b addr=%h", i, f_gnt0, f_gnt1, f_addr);
      @(posedge CLK);
    end
    // Port-0 read against port-1 write: guard counter is clear, so port 0 wins.
    #1 f_we0 = 1'b0;
    @(negedge CLK);
    chk("fx_mix_gnt0", {31'd0, f_gnt0}, 32'd1);
    chk("fx_mix_rden", {31'd0, f_rden}, 32'd1);
    chk("fx_mix_addr", {18'd0, f_addr}, 32'h0000_0100);
    $display("fx mix: gnt=%b%b rden=%b wen=%b", f_gnt0, f_gnt1, f_rden, f_wen);
    @(posedge CLK);
    #1 f_req0 = 1'b0;
    @(negedge CLK);
    chk("fx_after_gnt1", {31'd0, f_gnt1}, 32'd1);
    chk("fx_after_rvalid0", {31'd0, f_rvalid0}, 32'd1);
    chk("fx_after_rdata", f_rdata, 32'hFEED_C0DE);
    $display("fx tail: gnt=%b%b rvalid=%b%b", f_gnt0, f_gnt1, f_rvalid0, f_rvalid1);
    @(posedge CLK);
    #1 f_req1 = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
